uart_data_rx: RTL
=================

Name: uart_data_rx

Overview:
- UART receive stage that reassembles a multi-byte word.
- Sits downstream of uart_data_tx, either across the serial link or in a loopback bench.
- Samples the asynchronous uart_rx line and decodes 8N1 frames. Packs DATA_WIDTH/8 consecutive bytes into one word, then pulses rx_done.
- Byte order, baud table and clock assumptions match uart_data_tx, so a word sent by uart_data_tx is recovered bit-exact.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8 and at least 8. NBYTES = DATA_WIDTH/8.
- MSB_FIRST, 0, byte order. 0: the first received byte lands in data[7:0]. 1: the first received byte lands in data[DATA_WIDTH-1:DATA_WIDTH-8].
- CLK_FREQ, 50_000_000, clk frequency in Hz.
- TIMEOUT_BITS, 20, idle gap between bytes of one word, in bit periods, after which a partial word is discarded.

Ports:
- clk, input, 1, system clock (20 ns at the default CLK_FREQ).
- reset_n, input, 1, synchronous active-low reset.
- uart_rx, input, 1, asynchronous serial line; idles high.
- baud_set, input, 3, rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200; 5-7 behave as 0.
- data, output, DATA_WIDTH, last completed word; holds its value until the next word completes.
- rx_done, output, 1, one-cycle pulse; data is valid in the same cycle.
- frame_error, output, 1, one-cycle pulse on a bad stop bit.
- timeout, output, 1, one-cycle pulse when a partial word is discarded by the gap timer.
- rx_busy, output, 1, high from start-bit detect until the word ends (done, error or timeout).

Behaviour:
- Reset: registered inside `if (!reset_n)` on posedge clk only.
  - data=0; rx_done, frame_error, timeout, rx_busy = 0.
  - FSM to IDLE; byte counter = 0; synchroniser flops = 1.
  - Reset mid-frame abandons the frame; no pulse is emitted.
- Input conditioning: uart_rx passes through a 2-FF synchroniser and then a third register for edge detect. A start edge is synchronised 1 then 0.
- Bit period: BAUD_CNT = CLK_FREQ/baud - 1, i.e. 5207/2603/1301/867/433 at 50 MHz. HALF = BAUD_CNT/2.
  - baud_set is latched at start-bit detect and held for the whole byte.
- Byte FSM:
  - IDLE: on a falling edge of the synchronised line -> START; clear the bit-period counter; assert rx_busy.
  - START: at counter == HALF, re-sample the line.
    - Line high (glitch): -> IDLE; rx_busy drops unless a word is in progress.
    - Line low: -> DATA; restart the counter.
  - DATA: at each counter == BAUD_CNT, sample one bit, 8 bits total, LSB first into a shift register -> STOP.
  - STOP: at counter == BAUD_CNT, sample.
    - Sample 1: byte accepted -> IDLE.
    - Sample 0: frame_error pulse next cycle; discard the partial word (byte counter = 0); -> WAIT_HIGH.
  - WAIT_HIGH: stay until the synchronised line is 1, then -> IDLE. This prevents a break condition from retriggering.
- Word assembly:
  - Each accepted byte is written to lane byte_cnt. The lane is reversed when MSB_FIRST=1.
  - byte_cnt increments on each accepted byte.
  - When the last byte (byte_cnt == NBYTES-1) is accepted: on the next clk the full word is copied to data, rx_done pulses for one cycle, byte_cnt resets to 0 and rx_busy drops.
  - Latency: rx_done is exactly 1 cycle after the stop-bit sample edge of the final byte.
  - data never shows a partially assembled word.
- Gap timeout:
  - In IDLE with 0 < byte_cnt < NBYTES, a gap counter increments each clk and is cleared on start-bit detect.
  - When it reaches TIMEOUT_BITS*(BAUD_CNT+1): timeout pulses one cycle, byte_cnt = 0, rx_busy = 0, data unchanged.
- Simultaneous events:
  - A start edge in the same cycle as the timeout expiry is treated as a start; no timeout is raised.
  - rx_done, frame_error and timeout are mutually exclusive by construction.
- NBYTES=1 (DATA_WIDTH=8): every valid frame produces rx_done; timeout never fires.
- baud_set changes only take effect at the next start-bit detect.

Test Plan:
- Loopback to uart_data_tx (DATA_WIDTH=32, MSB_FIRST=0, baud_set=4), send 32'h01234567 -> exactly one rx_done pulse; data=32'h01234567; frame_error and timeout stay 0.
- Back-to-back words 32'h12345678 then 32'h23456789 from the transmitter -> two rx_done pulses, data matches each word in order; rx_busy low between words.
- MSB_FIRST=1 on both ends, bytes driven 0xDE,0xAD,0xBE,0xEF -> data=32'hDEADBEEF.
  - Same bytes with MSB_FIRST=0 -> 32'hEFBEADDE.
- 100 ns low glitch on uart_rx, then a valid word -> no pulse from the glitch; the word is received correctly.
- Second byte driven with stop bit = 0 -> frame_error single pulse, no rx_done. After the line idles, a full valid word is received correctly.
- Timeout and reset:
  - Two bytes sent, then line idle for more than 20 bit periods -> timeout pulse, data unchanged. The next 4-byte word is received intact.
  - reset_n=0 for one cycle during a data bit -> all outputs 0; the next word is received correctly.

Source files
------------

// File: rtl/uart_data_rx.sv
// uart_data_rx
// UART receive stage that decodes 8N1 frames and packs NBYTES = DATA_WIDTH/8
// consecutive bytes into one word. It is the receiving partner of uart_data_tx.
//
// Ports:
//   clk         system clock
//   reset_n     synchronous active-low reset
//   uart_rx     asynchronous serial line, idles high
//   baud_set    rate select 0..4 = 9600/19200/38400/57600/115200, 5..7 = 9600
//   data        last completed word, held until the next word completes
//   rx_done     one-cycle pulse, data valid in the same cycle
//   frame_error one-cycle pulse on a bad stop bit
//   timeout     one-cycle pulse when a partial word is dropped by the gap timer
//   rx_busy     high from start-bit detect until the word ends

module uart_data_rx #(
    parameter int DATA_WIDTH   = 32,
    parameter int MSB_FIRST    = 0,
    parameter int CLK_FREQ     = 50_000_000,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  uart_rx,
    input  logic [2:0]            baud_set,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  rx_done,
    output logic                  frame_error,
    output logic                  timeout,
    output logic                  rx_busy
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW     = $clog2(CLK_FREQ / 9600 + 1);
    localparam int GW     = $clog2(TIMEOUT_BITS * (CLK_FREQ / 9600) + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rxState_e;

    // Bit period minus one for each rate; unused codes fall back to 9600.
    function automatic logic [CW-1:0] baudCount(input logic [2:0] sel);
        case (sel)
            3'd1:    baudCount = CW'(CLK_FREQ / 19200 - 1);
            3'd2:    baudCount = CW'(CLK_FREQ / 38400 - 1);
            3'd3:    baudCount = CW'(CLK_FREQ / 57600 - 1);
            3'd4:    baudCount = CW'(CLK_FREQ / 115200 - 1);
            default: baudCount = CW'(CLK_FREQ / 9600 - 1);
        endcase
    endfunction

    rxState_e              state_q, state_d;
    logic                  syncMeta_q, syncLine_q, lineDly_q;
    logic [CW-1:0]         periodCnt_q, periodCnt_d;
    logic [CW-1:0]         baudCnt_q, baudCnt_d;
    logic [2:0]            bitIdx_q, bitIdx_d;
    logic [7:0]            shift_q, shift_d;
    logic [BCW-1:0]        byteCnt_q, byteCnt_d;
    logic [GW-1:0]         gapCnt_q, gapCnt_d;
    logic [DATA_WIDTH-1:0] wordAsm_q, wordAsm_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  rxDone_q, rxDone_d;
    logic                  frameErr_q, frameErr_d;
    logic                  timeout_q, timeout_d;
    logic                  busy_q, busy_d;

    logic                  startEdge;
    logic [CW-1:0]         halfCnt;
    logic [GW-1:0]         gapLimit;
    logic [DATA_WIDTH-1:0] mergedWord;

    assign startEdge = lineDly_q & ~syncLine_q;
    assign halfCnt   = baudCnt_q >> 1;
    // The gap limit follows the rate latched for the most recent byte.
    assign gapLimit  = GW'(TIMEOUT_BITS) * (GW'(baudCnt_q) + GW'(1));

    // The assembly word with the byte just received dropped into its lane.
    always_comb begin
        mergedWord = wordAsm_q;
        if (MSB_FIRST != 0) begin
            mergedWord[(NBYTES - 1 - int'(byteCnt_q)) * 8 +: 8] = shift_q;
        end else begin
            mergedWord[int'(byteCnt_q) * 8 +: 8] = shift_q;
        end
    end

    // Next-state logic; pulse outputs default low so they last one cycle.
    always_comb begin
        state_d     = state_q;
        periodCnt_d = periodCnt_q;
        baudCnt_d   = baudCnt_q;
        bitIdx_d    = bitIdx_q;
        shift_d     = shift_q;
        byteCnt_d   = byteCnt_q;
        gapCnt_d    = '0;
        wordAsm_d   = wordAsm_q;
        data_d      = data_q;
        rxDone_d    = 1'b0;
        frameErr_d  = 1'b0;
        timeout_d   = 1'b0;
        busy_d      = busy_q;

        case (state_q)
            IDLE: begin
                // A start edge beats a timeout expiring in the same cycle.
                if (startEdge) begin
                    state_d     = START;
                    periodCnt_d = '0;
                    baudCnt_d   = baudCount(baud_set);
                    busy_d      = 1'b1;
                end else if (byteCnt_q != '0) begin
                    if (gapCnt_q == gapLimit - GW'(1)) begin
                        timeout_d = 1'b1;
                        byteCnt_d = '0;
                        busy_d    = 1'b0;
                    end else begin
                        gapCnt_d = gapCnt_q + GW'(1);
                    end
                end
            end

            START: begin
                if (periodCnt_q == halfCnt) begin
                    if (syncLine_q) begin
                        state_d = IDLE;
                        if (byteCnt_q == '0) begin
                            busy_d = 1'b0;
                        end
                    end else begin
                        state_d     = DATA;
                        periodCnt_d = '0;
                        bitIdx_d    = '0;
                    end
                end else begin
                    periodCnt_d = periodCnt_q + CW'(1);
                end
            end

            DATA: begin
                if (periodCnt_q == baudCnt_q) begin
                    periodCnt_d = '0;
                    shift_d     = {syncLine_q, shift_q[7:1]};
                    bitIdx_d    = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    periodCnt_d = periodCnt_q + CW'(1);
                end
            end

            STOP: begin
                if (periodCnt_q == baudCnt_q) begin
                    periodCnt_d = '0;
                    if (syncLine_q) begin
                        state_d = IDLE;
                        if (byteCnt_q == LAST_BYTE) begin
                            data_d    = mergedWord;
                            rxDone_d  = 1'b1;
                            byteCnt_d = '0;
                            busy_d    = 1'b0;
                        end else begin
                            wordAsm_d = mergedWord;
                            byteCnt_d = byteCnt_q + BCW'(1);
                        end
                    end else begin
                        state_d    = WAIT_HIGH;
                        frameErr_d = 1'b1;
                        byteCnt_d  = '0;
                        busy_d     = 1'b0;
                    end
                end else begin
                    periodCnt_d = periodCnt_q + CW'(1);
                end
            end

            // Hold off until the line recovers so a break cannot retrigger.
            WAIT_HIGH: begin
                if (syncLine_q) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; the synchroniser resets to the idle level.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            syncMeta_q  <= 1'b1;
            syncLine_q  <= 1'b1;
            lineDly_q   <= 1'b1;
            periodCnt_q <= '0;
            baudCnt_q   <= baudCount(3'd0);
            bitIdx_q    <= '0;
            shift_q     <= '0;
            byteCnt_q   <= '0;
            gapCnt_q    <= '0;
            wordAsm_q   <= '0;
            data_q      <= '0;
            rxDone_q    <= 1'b0;
            frameErr_q  <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            syncMeta_q  <= uart_rx;
            syncLine_q  <= syncMeta_q;
            lineDly_q   <= syncLine_q;
            periodCnt_q <= periodCnt_d;
            baudCnt_q   <= baudCnt_d;
            bitIdx_q    <= bitIdx_d;
            shift_q     <= shift_d;
            byteCnt_q   <= byteCnt_d;
            gapCnt_q    <= gapCnt_d;
            wordAsm_q   <= wordAsm_d;
            data_q      <= data_d;
            rxDone_q    <= rxDone_d;
            frameErr_q  <= frameErr_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
        end
    end

    assign data        = data_q;
    assign rx_done     = rxDone_q;
    assign frame_error = frameErr_q;
    assign timeout     = timeout_q;
    assign rx_busy     = busy_q;

endmodule
